// File: rtl/mac16_accumulator.sv
// mac16_accumulator
// Accumulation stage behind the 16x16 multiplier. It registers each unsigned
// 32-bit product in a one-entry input stage. A small FSM (IDLE/ACCUM/HOLD)
// adds the product into an ACC_W-bit accumulator. When the last product of a
// frame arrives, the frame sum and term count are held until the consumer
// takes them.
//
// Build option:
//   SATURATE_EN  when defined, the sum clamps to all-ones on overflow.
//                When undefined, the sum wraps and the overflow flag is sticky.
//
// ACC_W must be at least 32 so that a single product fits the accumulator.

module mac16_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      prod,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // FSM state
  state_e state_q;
  state_e state_d;

  // Stage 1 input register
  logic        s1_valid_q;
  logic        s1_valid_d;
  logic [31:0] s1_prod_q;
  logic [31:0] s1_prod_d;
  logic        s1_last_q;
  logic        s1_last_d;

  // Accumulator registers; these drive the result ports directly
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;

  // Handshake and arithmetic intermediates
  logic             s1_consume;
  logic             prod_accept;
  logic [ACC_W:0]   sum_wide;
  logic             sum_carry;
  logic [ACC_W-1:0] acc_add;
  logic             ovf_add;
  logic [CNT_W-1:0] cnt_inc;

  // Stage 1 drains into the FSM whenever a result is not being held
  always_comb begin
    s1_consume = 1'b0;
    if (s1_valid_q && (state_q != ST_HOLD)) begin
      s1_consume = 1'b1;
    end else begin
      s1_consume = 1'b0;
    end
  end

  // Input handshake: stage 1 is free if it is empty or emptying this cycle
  always_comb begin
    prod_ready  = 1'b0;
    prod_accept = 1'b0;
    if (rst) begin
      prod_ready = 1'b0;
    end else begin
      prod_ready = !s1_valid_q || s1_consume;
    end
    prod_accept = prod_valid && prod_ready;
  end

  // Stage 1 next value: load on accept, clear when drained, otherwise hold
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_last_d  = s1_last_q;
    if (prod_accept) begin
      s1_valid_d = 1'b1;
      s1_prod_d  = prod;
      s1_last_d  = prod_last;
    end else if (s1_consume) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Widened add: the extra top bit is the carry-out of the accumulator
  always_comb begin
    sum_wide  = {1'b0, acc_q} + (ACC_W + 1)'(s1_prod_q);
    sum_carry = sum_wide[ACC_W];
    ovf_add   = ovf_q | sum_carry;
`ifdef SATURATE_EN
    // Once overflowed, the frame stays pinned at the maximum value
    if (ovf_q || sum_carry) begin
      acc_add = {ACC_W{1'b1}};
    end else begin
      acc_add = sum_wide[ACC_W-1:0];
    end
`else
    // Wrap modulo 2^ACC_W; the flag remembers any carry in the frame
    acc_add = sum_wide[ACC_W-1:0];
`endif
  end

  // Term counter increment that sticks at its maximum instead of wrapping
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q == CNT_MAX) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + CNT_ONE;
    end
  end

  // Accumulator update: the first term of a frame restarts the sum, later terms add
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (s1_consume) begin
      case (state_q)
        ST_IDLE: begin
          acc_d = ACC_W'(s1_prod_q);
          cnt_d = CNT_ONE;
          ovf_d = 1'b0;
        end
        ST_ACCUM: begin
          acc_d = acc_add;
          cnt_d = cnt_inc;
          ovf_d = ovf_add;
        end
        default: begin
          acc_d = acc_q;
          cnt_d = cnt_q;
          ovf_d = ovf_q;
        end
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  // FSM next state: close the frame on the last term, reopen after the result is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (s1_consume) begin
          if (s1_last_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (acc_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: the result is only valid while it is being held
  always_comb begin
    acc_valid = 1'b0;
    case (state_q)
      ST_HOLD:  acc_valid = 1'b1;
      default:  acc_valid = 1'b0;
    endcase
  end

  // The result ports read straight from the accumulator registers
  always_comb begin
    acc_out   = acc_q;
    acc_count = cnt_q;
    acc_ovf   = ovf_q;
  end

  // State register; reset discards any open frame and any held product
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= 32'd0;
      s1_last_q  <= 1'b0;
      acc_q      <= {ACC_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_last_q  <= s1_last_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac16_accumulator.sv
// Directed testbench for mac16_accumulator.
// It drives two instances from the same stimulus:
//   u_dut    default widths (ACC_W=40, CNT_W=8)
//   u_small  ACC_W=32, CNT_W=2, for the overflow and count-saturation cases
// Define SATURATE_EN for both RTL and bench to check the clamping build.

module tb_mac16_accumulator;

  logic        clk;
  logic        rst;
  logic [31:0] prod;
  logic        prod_valid;
  logic        prod_last;
  logic        acc_ready;

  logic        prod_ready;
  logic [39:0] acc_out;
  logic [7:0]  acc_count;
  logic        acc_ovf;
  logic        acc_valid;

  logic        s_prod_ready;
  logic [31:0] s_acc_out;
  logic [1:0]  s_acc_count;
  logic        s_acc_ovf;
  logic        s_acc_valid;

  int n_checks;
  int n_errors;

  mac16_accumulator #(.ACC_W(40), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .acc_count  (acc_count),
    .acc_ovf    (acc_ovf),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready)
  );

  mac16_accumulator #(.ACC_W(32), .CNT_W(2)) u_small (
    .clk        (clk),
    .rst        (rst),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (s_prod_ready),
    .acc_out    (s_acc_out),
    .acc_count  (s_acc_count),
    .acc_ovf    (s_acc_ovf),
    .acc_valid  (s_acc_valid),
    .acc_ready  (acc_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and wait (bounded) for the handshake edge
  task automatic send(input logic [31:0] p, input logic last);
    logic ok;
    ok = 1'b0;
    prod       = p;
    prod_last  = last;
    prod_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      ok = prod_ready;
      step();
      if (ok) break;
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  // Advance at least one edge, until a result is valid (bounded)
  task automatic wait_valid();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  int accepted;
  logic rdy;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    prod       = 32'd0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    acc_ready  = 1'b1;

    // Reset values, both while held and just after release
    step();
    step();
    chk("rst_ready",  {63'd0, prod_ready}, 64'd0);
    chk("rst_valid",  {63'd0, acc_valid},  64'd0);
    chk("rst_out",    {24'd0, acc_out},    64'd0);
    chk("rst_count",  {56'd0, acc_count},  64'd0);
    chk("rst_ovf",    {63'd0, acc_ovf},    64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, prod_ready}, 64'd1);
    chk("post_rst_valid", {63'd0, acc_valid},  64'd0);

    // One-term frame: valid one edge after acceptance
    send(32'h0000_0010, 1'b1);
    chk("one_valid_early", {63'd0, acc_valid}, 64'd0);
    step();
    chk("one_valid", {63'd0, acc_valid}, 64'd1);
    chk("one_out",   {24'd0, acc_out},   64'h10);
    chk("one_count", {56'd0, acc_count}, 64'd1);
    chk("one_ovf",   {63'd0, acc_ovf},   64'd0);
    step();
    chk("one_release", {63'd0, acc_valid}, 64'd0);

    // Back-to-back 1,2,3,4 then an immediate next frame
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("b2b_ready", {63'd0, prod_ready}, 64'd1);
      send(32'(i), (i == 4));
    end
    send(32'hFFFE_0001, 1'b1);
    chk("b2b_valid", {63'd0, acc_valid}, 64'd1);
    chk("b2b_out",   {24'd0, acc_out},   64'd10);
    chk("b2b_count", {56'd0, acc_count}, 64'd4);
    wait_valid();
    chk("b2b2_out",   {24'd0, acc_out},   64'hFFFE_0001);
    chk("b2b2_count", {56'd0, acc_count}, 64'd1);
    step();

    // Backpressure: hold the result for 5 cycles while products keep coming
    acc_ready = 1'b0;
    send(32'd100, 1'b1);
    wait_valid();
    chk("bp_out0", {24'd0, acc_out}, 64'd100);
    accepted   = 0;
    prod       = 32'd200;
    prod_last  = 1'b1;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      rdy = prod_ready;
      step();
      if (rdy) accepted = accepted + 1;
      chk("bp_hold_out",   {24'd0, acc_out},   64'd100);
      chk("bp_hold_valid", {63'd0, acc_valid}, 64'd1);
    end
    chk("bp_accepted", 64'(accepted), 64'd1);
    chk("bp_ready",    {63'd0, prod_ready}, 64'd0);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    acc_ready  = 1'b1;
    step();
    chk("bp_release", {63'd0, acc_valid}, 64'd0);
    step();
    chk("bp_next_valid", {63'd0, acc_valid}, 64'd1);
    chk("bp_next_out",   {24'd0, acc_out},   64'd200);
    chk("bp_next_count", {56'd0, acc_count}, 64'd1);
    step();

    // Overflow at 32 bits; the 40-bit instance holds the full sum
    send(32'hFFFE_0001, 1'b0);
    send(32'hFFFE_0001, 1'b1);
    wait_valid();
    chk("ovf_wide_out", {24'd0, acc_out}, 64'h1_FFFC_0002);
    chk("ovf_wide_flag", {63'd0, acc_ovf}, 64'd0);
`ifdef SATURATE_EN
    chk("ovf_small_out", {32'd0, s_acc_out}, 64'hFFFF_FFFF);
`else
    chk("ovf_small_out", {32'd0, s_acc_out}, 64'hFFFC_0002);
`endif
    chk("ovf_small_flag",  {63'd0, s_acc_ovf},   64'd1);
    chk("ovf_small_count", {62'd0, s_acc_count}, 64'd2);
    step();
    send(32'd3, 1'b1);
    wait_valid();
    chk("ovf_clear_flag", {63'd0, s_acc_ovf}, 64'd0);
    chk("ovf_clear_out",  {32'd0, s_acc_out}, 64'd3);
    step();

    // Reset in the middle of a frame
    send(32'd7, 1'b0);
    send(32'd9, 1'b0);
    step();
    chk("mid_partial", {24'd0, acc_out}, 64'd16);
    rst = 1'b1;
    step();
    chk("mid_rst_out",   {24'd0, acc_out},    64'd0);
    chk("mid_rst_count", {56'd0, acc_count},  64'd0);
    chk("mid_rst_valid", {63'd0, acc_valid},  64'd0);
    chk("mid_rst_ready", {63'd0, prod_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_post_ready", {63'd0, prod_ready}, 64'd1);
    send(32'd5, 1'b1);
    wait_valid();
    chk("mid_next_out",   {24'd0, acc_out},   64'd5);
    chk("mid_next_count", {56'd0, acc_count}, 64'd1);
    step();

    // Count saturation: five 1s
    for (int i = 1; i <= 5; i++) begin
      send(32'd1, (i == 5));
    end
    wait_valid();
    chk("sat_small_count", {62'd0, s_acc_count}, 64'd3);
    chk("sat_small_out",   {32'd0, s_acc_out},   64'd5);
    chk("sat_wide_count",  {56'd0, acc_count},   64'd5);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
